simon_seq_player: RTL and testbench
===================================

Name: simon_seq_player

Overview:
Playback stage that feeds the Simon game controller. It takes the 30-bit colour sequence word (ten 3-bit slots, slot 0 in bits [2:0]) and the current round count. It then flashes the first `count` colours, in order, on four one-hot lamp outputs with programmable on/off timing. When playback finishes it pulses Done, which tells the game controller to enter user-input collection.

Parameters:
ON_CYCLES, 25_000_000, clock cycles each colour is lit (0.25 s at 100 MHz); legal values 1..2^32-1.
OFF_CYCLES, 12_500_000, clock cycles of dark gap before each colour; legal values 1..2^32-1.
MAX_ROUNDS, 10, number of slots in the colour word; count is clamped to this value.

Ports:
Clk  in  1  system clock.
Reset  in  1  asynchronous, active-high reset.
Start  in  1  request to begin playback; sampled only in IDLE.
Abort  in  1  synchronous cancel of playback in progress.
colors  in  30  sequence word; slot i = colors[3i+2:3i]; 1=RED, 2=BLUE, 3=YELLOW, 4=GREEN.
count  in  4  number of slots to play.
led  out  4  one-hot lamp: bit0 RED, bit1 BLUE, bit2 YELLOW, bit3 GREEN.
cur_idx  out  4  slot index currently being played (0-based).
Busy  out  1  high in every state except IDLE.
Done  out  1  one-cycle pulse when playback completes.
Error  out  1  sticky flag: an invalid slot code was played.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; led=0, cur_idx=0, Busy=0, Done=0, Error=0; timers and shadow registers cleared.
- States: IDLE, GAP, SHOW, FIN.
- IDLE, Start=1 at cycle k:
  - Latch colors into a shadow register.
  - Latch n = min(count, MAX_ROUNDS).
  - Clear Error; set cur_idx=0.
  - If n=0, go to FIN; otherwise go to GAP.
  - Busy goes high at k+1.
  - colors and count changes after the Start cycle have no effect.
- GAP: led=0 for exactly OFF_CYCLES cycles, then go to SHOW.
- SHOW:
  - led = decode(slot[cur_idx]) for exactly ON_CYCLES cycles.
  - On the last cycle: if cur_idx==n-1, go to FIN; otherwise increment cur_idx and go to GAP.
- FIN: Done=1 and led=0 for exactly one cycle; Busy=1; next state IDLE.
- Start outside IDLE is ignored. Start held high in IDLE after FIN begins a new playback.
- Abort=1 in GAP or SHOW:
  - Next state IDLE; led=0 next cycle; Done is not asserted; cur_idx resets to 0; Error is held.
  - Abort in IDLE or FIN has no effect. If Abort and the FIN cycle coincide, Done still pulses.
  - Abort has priority over timer expiry.
- Invalid slot code (0, 5, 6, 7) in SHOW: led=0 for the full ON_CYCLES; Error is set and stays set until the next accepted Start or Reset. Timing is unchanged.
- Timer: a 32-bit down-counter, reloaded on every state entry. No wrap-around is reachable within legal parameter values.
- Total latency from Start cycle to Done cycle = n*(OFF_CYCLES+ON_CYCLES) + 1 cycles; for n=0, Done is at k+1.
- led is registered, never multi-hot, and updates on the cycle after state entry into SHOW or GAP.

Decomposition:
- Package simon_pkg:
  - colour codes RED/BLUE/YELLOW/GREEN = 1..4;
  - one-hot lamp constants;
  - MAX_ROUNDS=10 and SLOT_W=3;
  - player state encoding.
  - The game controller shares this package.
- One sub-module, simon_color_decode: combinational; 3-bit code -> 4-bit one-hot lamp plus valid bit.

Test Plan:
(All tests use ON_CYCLES=4, OFF_CYCLES=2.)
1. colors=30'h19 (slot0 RED, slot1 YELLOW), count=2, Start at cycle 0:
   - led=0 at cycles 1-2; led=4'b0001 at cycles 3-6; led=0 at cycles 7-8; led=4'b0100 at cycles 9-12.
   - Done=1 at cycle 13 only; Busy high for cycles 1-13; Error=0.
2. count=0, Start -> Done pulses at cycle 1; led stays 0 throughout.
3. count=15, colors slots 0-9 = 4,3,2,1,4,3,2,1,4,3 -> exactly 10 flashes in that order, ending with cur_idx=9; Done at cycle 61.
4. colors=30'h6 (slot0 code 6), count=1 -> led=0 for the whole sequence; Error=1 from cycle 3; Done at cycle 7; the next Start clears Error.
5. Abort at cycle 5 during test 1 -> led=0 and Busy=0 from cycle 6; no Done; a new Start is accepted at cycle 6.
6. Reset asserted asynchronously mid-SHOW -> all outputs 0 immediately. A Start pulse during Busy in test 1 is ignored (timing unchanged).

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game: colour codes, lamp encodings,
// sequence geometry and the playback FSM state type.
// The game controller imports this package as well.
package simon_pkg;

    localparam int unsigned MAX_ROUNDS = 10;
    localparam int unsigned SLOT_W     = 3;
    localparam int unsigned COLORS_W   = MAX_ROUNDS * SLOT_W;

    // Colour codes as stored in the sequence word
    localparam logic [SLOT_W-1:0] COL_RED    = 3'd1;
    localparam logic [SLOT_W-1:0] COL_BLUE   = 3'd2;
    localparam logic [SLOT_W-1:0] COL_YELLOW = 3'd3;
    localparam logic [SLOT_W-1:0] COL_GREEN  = 3'd4;

    // One-hot lamp drive
    localparam logic [3:0] LAMP_OFF    = 4'b0000;
    localparam logic [3:0] LAMP_RED    = 4'b0001;
    localparam logic [3:0] LAMP_BLUE   = 4'b0010;
    localparam logic [3:0] LAMP_YELLOW = 4'b0100;
    localparam logic [3:0] LAMP_GREEN  = 4'b1000;

    typedef enum logic [1:0] {
        StIdle,
        StGap,
        StShow,
        StFin
    } player_state_e;

    // Extract slot idx from the sequence word; out-of-range idx gives 0
    function automatic logic [SLOT_W-1:0] slot_code(input logic [COLORS_W-1:0] word,
                                                    input logic [3:0]          idx);
        slot_code = '0;
        for (int i = 0; i < int'(MAX_ROUNDS); i++) begin
            if (idx == 4'(i)) slot_code = word[i*SLOT_W +: SLOT_W];
        end
    endfunction

endpackage

// File: rtl/simon_seq_player_if.sv
// Bundle between the game controller (master) and the sequence player (slave).
//   Start, Abort   : playback request / cancel
//   colors, count  : sequence word (slot 0 in [2:0]) and number of slots to play
//   led, cur_idx   : one-hot lamp and slot being played
//   Busy, Done     : activity flag and completion pulse
//   Error          : sticky invalid-code flag
interface simon_seq_player_if;
    import simon_pkg::*;

    logic                Start;
    logic                Abort;
    logic [COLORS_W-1:0] colors;
    logic [3:0]          count;
    logic [3:0]          led;
    logic [3:0]          cur_idx;
    logic                Busy;
    logic                Done;
    logic                Error;

    modport master (
        output Start, Abort, colors, count,
        input  led, cur_idx, Busy, Done, Error
    );

    modport slave (
        input  Start, Abort, colors, count,
        output led, cur_idx, Busy, Done, Error
    );

endinterface

// File: rtl/simon_color_decode.sv
// Colour code to one-hot lamp decoder (purely combinational).
//   code  : 3-bit colour code
//   lamp  : one-hot lamp, all-zero for invalid codes
//   valid : code is one of RED/BLUE/YELLOW/GREEN
module simon_color_decode
    import simon_pkg::*;
(
    input  logic [SLOT_W-1:0] code,
    output logic [3:0]        lamp,
    output logic              valid
);

    always_comb begin
        lamp  = LAMP_OFF;
        valid = 1'b1;
        case (code)
            COL_RED:    lamp = LAMP_RED;
            COL_BLUE:   lamp = LAMP_BLUE;
            COL_YELLOW: lamp = LAMP_YELLOW;
            COL_GREEN:  lamp = LAMP_GREEN;
            default:    valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/simon_seq_player.sv
// Simon sequence player: flashes the first `count` colours of the latched
// sequence word, each preceded by a dark gap, then pulses Done.
//   Clk, Reset : clock, asynchronous active-high reset
//   bus        : slave side of simon_seq_player_if
// The round limit comes from simon_pkg so it always matches the word width.
module simon_seq_player
    import simon_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 25_000_000,
    parameter int unsigned OFF_CYCLES = 12_500_000
) (
    input  logic              Clk,
    input  logic              Reset,
    simon_seq_player_if.slave bus
);

    player_state_e       state_q, state_d;
    logic [31:0]         timer_q, timer_d;
    logic [COLORS_W-1:0] colors_q, colors_d;
    logic [3:0]          n_q, n_d;
    logic [3:0]          cur_idx_q, cur_idx_d;
    logic [3:0]          led_q, led_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                start_ok;
    logic                expired;
    logic                last_slot;
    logic [3:0]          n_start;
    logic [SLOT_W-1:0]   code;
    logic [3:0]          lamp;
    logic                code_valid;

    assign start_ok  = (state_q == StIdle) && bus.Start;
    assign expired   = (timer_q == '0);
    assign last_slot = (cur_idx_q == n_q - 4'd1);
    assign n_start   = (bus.count > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : bus.count;

    // Decode the slot that will be shown next cycle, so led is registered
    // in step with the state.
    assign code = slot_code(colors_q, cur_idx_d);

    simon_color_decode u_decode (
        .code  (code),
        .lamp  (lamp),
        .valid (code_valid)
    );

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic; Abort outranks timer expiry
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.Start) state_d = (n_start == 4'd0) ? StFin : StGap;
            StGap: begin
                if (bus.Abort)    state_d = StIdle;
                else if (expired) state_d = StShow;
            end
            StShow: begin
                if (bus.Abort)    state_d = StIdle;
                else if (expired) state_d = last_slot ? StFin : StGap;
            end
            StFin:  state_d = StIdle;
        endcase
    end

    // Output and datapath next-state logic
    always_comb begin
        timer_d   = timer_q;
        colors_d  = colors_q;
        n_d       = n_q;
        cur_idx_d = cur_idx_q;
        error_d   = error_q;

        if (start_ok) begin
            colors_d  = bus.colors;
            n_d       = n_start;
            cur_idx_d = '0;
            error_d   = 1'b0;
        end else if ((state_q == StGap || state_q == StShow) && bus.Abort) begin
            cur_idx_d = '0;
        end else if (state_q == StShow && expired && !last_slot) begin
            cur_idx_d = cur_idx_q + 4'd1;
        end

        // Reload on every state entry, otherwise count down to zero
        if (state_d != state_q) begin
            unique case (state_d)
                StGap:   timer_d = 32'(OFF_CYCLES - 1);
                StShow:  timer_d = 32'(ON_CYCLES - 1);
                default: timer_d = '0;
            endcase
        end else if (!expired) begin
            timer_d = timer_q - 32'd1;
        end

        if (state_d == StShow && !code_valid) error_d = 1'b1;

        led_d  = (state_d == StShow) ? lamp : LAMP_OFF;
        done_d = (state_d == StFin);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            timer_q   <= '0;
            colors_q  <= '0;
            n_q       <= '0;
            cur_idx_q <= '0;
            led_q     <= LAMP_OFF;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            colors_q  <= colors_d;
            n_q       <= n_d;
            cur_idx_q <= cur_idx_d;
            led_q     <= led_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign bus.led     = led_q;
    assign bus.cur_idx = cur_idx_q;
    assign bus.Busy    = (state_q != StIdle);
    assign bus.Done    = done_q;
    assign bus.Error   = error_q;

endmodule

// File: tb/tb_simon_seq_player.sv
module tb_simon_seq_player;
    import simon_pkg::*;

    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int PER = ON + OFF;

    logic Clk = 1'b0;
    logic Reset;

    simon_seq_player_if bus_if ();

    simon_seq_player #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_if)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_lamp [10];

    // Slots 9..0 = 3,4,1,2,3,4,1,2,3,4 (slot 0 GREEN, slot 1 YELLOW, ...)
    localparam logic [29:0] T3_COLORS = 30'h1C29C29C;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string name);
        check_eq({name, " led"},     32'(bus_if.led),     32'd0);
        check_eq({name, " cur_idx"}, 32'(bus_if.cur_idx), 32'd0);
        check_eq({name, " Busy"},    32'(bus_if.Busy),    32'd0);
        check_eq({name, " Done"},    32'(bus_if.Done),    32'd0);
        check_eq({name, " Error"},   32'(bus_if.Error),   32'd0);
    endtask

    // Called with Start/colors/count already driven for cycle 0. Checks every
    // cycle up to one past Done. Inputs are scrambled after the Start cycle.
    task automatic check_play(input string name, input int n, input int err_from,
                              input int glitch);
        step();
        bus_if.Start  = 1'b0;
        bus_if.colors = ~bus_if.colors;
        bus_if.count  = 4'd1;
        for (int c = 1; c <= n*PER + 2; c++) begin
            int j;
            int r;
            logic [3:0] e_led;
            logic [3:0] e_idx;
            j = (c - 1) / PER;
            r = (c - 1) % PER;
            e_led = (c <= n*PER && j < 10 && r >= OFF) ? exp_lamp[j] : 4'd0;
            e_idx = (c <= n*PER) ? 4'(j) : ((n == 0) ? 4'd0 : 4'(n - 1));
            check_eq($sformatf("%s c%0d led", name, c),     32'(bus_if.led),     32'(e_led));
            check_eq($sformatf("%s c%0d cur_idx", name, c), 32'(bus_if.cur_idx), 32'(e_idx));
            check_eq($sformatf("%s c%0d Done", name, c),    32'(bus_if.Done),
                     32'(c == n*PER + 1));
            check_eq($sformatf("%s c%0d Busy", name, c),    32'(bus_if.Busy),
                     32'(c <= n*PER + 1));
            check_eq($sformatf("%s c%0d Error", name, c),   32'(bus_if.Error),
                     32'(c >= err_from));
            bus_if.Start = (c == glitch);
            step();
        end
        bus_if.Start = 1'b0;
    endtask

    task automatic load_t1();
        bus_if.colors = 30'h19;
        bus_if.count  = 4'd2;
        exp_lamp[0]   = 4'b0001;
        exp_lamp[1]   = 4'b0100;
    endtask

    initial begin
        Reset         = 1'b1;
        bus_if.Start  = 1'b0;
        bus_if.Abort  = 1'b0;
        bus_if.colors = '0;
        bus_if.count  = '0;
        for (int i = 0; i < 10; i++) exp_lamp[i] = 4'd0;
        step();
        step();
        check_outputs_zero("reset");
        Reset = 1'b0;
        step();

        // 1: two slots RED, YELLOW
        load_t1();
        bus_if.Start = 1'b1;
        check_play("t1", 2, 1000, 0);

        // 6b: Start pulse while busy is ignored
        load_t1();
        bus_if.Start = 1'b1;
        check_play("t1_glitch", 2, 1000, 4);

        // 2: count=0 gives Done on the next cycle
        bus_if.colors = 30'h19;
        bus_if.count  = 4'd0;
        bus_if.Start  = 1'b1;
        check_play("t2", 0, 1000, 0);

        // 3: count=15 clamps to 10
        bus_if.colors = T3_COLORS;
        bus_if.count  = 4'd15;
        exp_lamp      = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h8, 4'h4, 4'h2, 4'h1, 4'h8, 4'h4};
        bus_if.Start  = 1'b1;
        check_play("t3", 10, 1000, 0);

        // 4: invalid code 6, Error from cycle 3 and sticky
        bus_if.colors = 30'h6;
        bus_if.count  = 4'd1;
        exp_lamp[0]   = 4'd0;
        bus_if.Start  = 1'b1;
        check_play("t4", 1, 3, 0);
        check_eq("t4 Error sticky", 32'(bus_if.Error), 32'd1);
        load_t1();
        bus_if.Start = 1'b1;
        check_play("t4_clear", 2, 1000, 0);

        // 5: Abort in SHOW at cycle 5, restart at cycle 6
        load_t1();
        bus_if.Start = 1'b1;
        step();
        bus_if.Start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check_eq($sformatf("t5 c%0d led", c), 32'(bus_if.led),
                     (c >= 3) ? 32'd1 : 32'd0);
            if (c == 5) bus_if.Abort = 1'b1;
            step();
        end
        bus_if.Abort = 1'b0;
        check_outputs_zero("t5 c6");
        bus_if.Start = 1'b1;
        check_play("t5_restart", 2, 1000, 0);

        // Abort in the second GAP (cycle 7, cur_idx=1)
        load_t1();
        bus_if.Start = 1'b1;
        step();
        bus_if.Start = 1'b0;
        for (int c = 1; c < 7; c++) step();
        check_eq("abort_gap c7 cur_idx", 32'(bus_if.cur_idx), 32'd1);
        check_eq("abort_gap c7 Busy",    32'(bus_if.Busy),    32'd1);
        bus_if.Abort = 1'b1;
        step();
        bus_if.Abort = 1'b0;
        check_outputs_zero("abort_gap c8");
        step();
        check_eq("abort_gap c9 Done", 32'(bus_if.Done), 32'd0);

        // 6a: async reset mid-SHOW of the 10-slot run (cycle 10, YELLOW, idx 1)
        bus_if.colors = T3_COLORS;
        bus_if.count  = 4'd15;
        bus_if.Start  = 1'b1;
        step();
        bus_if.Start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        check_eq("t6 pre led",     32'(bus_if.led),     32'h4);
        check_eq("t6 pre cur_idx", 32'(bus_if.cur_idx), 32'd1);
        #2 Reset = 1'b1;
        #1 check_outputs_zero("t6 async");
        #1 Reset = 1'b0;
        step();
        check_outputs_zero("t6 after");

        // Async reset clears a set Error mid-SHOW
        bus_if.colors = 30'h6;
        bus_if.count  = 4'd1;
        bus_if.Start  = 1'b1;
        step();
        bus_if.Start = 1'b0;
        for (int c = 1; c < 4; c++) step();
        check_eq("t6e pre Error", 32'(bus_if.Error), 32'd1);
        #2 Reset = 1'b1;
        #1 check_outputs_zero("t6e async");
        #1 Reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
